// File: rtl/siu_dmu_pkt_chk_if.sv
// SIU->DMU outbound header/payload tap: header-valid, data-request, data and
// per-segment parity, as seen by the packet checker.
interface siu_dmu_pkt_chk_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned PAR_W  = 8
);
  logic              hdr_vld;
  logic              datareq;
  logic [DATA_W-1:0] data;
  logic [PAR_W-1:0]  parity;

  modport master (output hdr_vld, output datareq, output data, output parity);
  modport slave  (input  hdr_vld, input  datareq, input  data, input  parity);
endinterface

// File: rtl/siu_dmu_pkt_chk.sv
// Outbound packet checker: tracks header/payload framing, checks segment parity
// on every beat, flags framing violations and keeps saturating event counters.
module siu_dmu_pkt_chk #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned PAR_W      = 8,
  parameter int unsigned BEATS      = 4,
  parameter int unsigned ODD_PARITY = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                iol2clk,
  input  logic                rst,
  input  logic                i_enable,
  input  logic                i_clr_cnt,
  siu_dmu_pkt_chk_if.slave    bus,
  output logic [DATA_W-1:0]   o_hdr_q,
  output logic                o_busy,
  output logic [3:0]          o_beat_idx,
  output logic                o_pkt_done,
  output logic                o_pkt_payload,
  output logic                o_parity_err,
  output logic [PAR_W-1:0]    o_parity_mask,
  output logic                o_proto_err,
  output logic [1:0]          o_proto_code,
  output logic [CNT_W-1:0]    o_hdr_cnt,
  output logic [CNT_W-1:0]    o_pay_cnt,
  output logic [CNT_W-1:0]    o_perr_cnt,
  output logic [CNT_W-1:0]    o_proto_cnt
);

  localparam int unsigned SEG_W     = DATA_W / PAR_W;
  localparam logic [3:0]  LAST_BEAT = 4'(BEATS - 1);
  localparam logic        ODD       = (ODD_PARITY != 0);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  // Input sampling stage: every output reflects the cycle sampled one edge earlier.
  logic              r_hdr_vld, r_datareq, r_enable, r_clr_cnt;
  logic [DATA_W-1:0] r_data;
  logic [PAR_W-1:0]  r_parity;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_beat, w_beat_nxt;

  logic             w_capture, w_check, w_done, w_done_pay;
  logic             w_hdr_inc, w_pay_inc, w_proto, w_perr;
  logic [1:0]       w_code;
  logic [PAR_W-1:0] w_exp, w_pmask;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic inc);
    return (inc && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
  endfunction

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      r_hdr_vld <= 1'b0;
      r_datareq <= 1'b0;
      r_enable  <= 1'b0;
      r_clr_cnt <= 1'b0;
      r_data    <= '0;
      r_parity  <= '0;
    end else begin
      r_hdr_vld <= bus.hdr_vld;
      r_datareq <= bus.datareq;
      r_enable  <= i_enable;
      r_clr_cnt <= i_clr_cnt;
      r_data    <= bus.data;
      r_parity  <= bus.parity;
    end
  end

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_exp = '0;
    for (int unsigned i = 0; i < PAR_W; i++) begin
      w_exp[i] = (^r_data[i*SEG_W +: SEG_W]) ^ ODD;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_capture   = 1'b0;
    w_check     = 1'b0;
    w_done      = 1'b0;
    w_done_pay  = 1'b0;
    w_hdr_inc   = 1'b0;
    w_pay_inc   = 1'b0;
    w_proto     = 1'b0;
    w_code      = 2'd0;
    case (r_state)
      IDLE: begin
        if (r_hdr_vld && r_enable) begin
          w_capture = 1'b1;
          w_check   = 1'b1;
          w_hdr_inc = 1'b1;
          if (r_datareq) begin
            w_state_nxt = PAYLOAD;
            w_beat_nxt  = '0;
          end else begin
            w_done = 1'b1;
          end
        end else if (r_datareq && !r_hdr_vld) begin
          w_proto = 1'b1;
          w_code  = 2'd2;
        end
      end
      PAYLOAD: begin
        w_check = 1'b1;
        if (r_hdr_vld) begin
          // Abort the running packet and restart from this header, enable or not.
          w_proto   = 1'b1;
          w_code    = 2'd1;
          w_capture = 1'b1;
          w_hdr_inc = 1'b1;
          w_beat_nxt = '0;
          if (r_datareq) begin
            w_state_nxt = PAYLOAD;
          end else begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end
        end else if (r_beat == LAST_BEAT) begin
          w_done      = 1'b1;
          w_done_pay  = 1'b1;
          w_pay_inc   = 1'b1;
          w_state_nxt = IDLE;
          w_beat_nxt  = '0;
        end else begin
          w_beat_nxt = r_beat + 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_beat_nxt  = '0;
      end
    endcase
    w_pmask = w_check ? (r_parity ^ w_exp) : '0;
    w_perr  = |w_pmask;
  end

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      o_hdr_q       <= '0;
      o_busy        <= 1'b0;
      o_beat_idx    <= '0;
      o_pkt_done    <= 1'b0;
      o_pkt_payload <= 1'b0;
      o_parity_err  <= 1'b0;
      o_parity_mask <= '0;
      o_proto_err   <= 1'b0;
      o_proto_code  <= 2'd0;
      o_hdr_cnt     <= '0;
      o_pay_cnt     <= '0;
      o_perr_cnt    <= '0;
      o_proto_cnt   <= '0;
    end else begin
      if (w_capture) begin
        o_hdr_q <= r_data;
      end
      o_busy        <= (w_state_nxt == PAYLOAD);
      o_beat_idx    <= w_beat_nxt;
      o_pkt_done    <= w_done;
      o_pkt_payload <= w_done_pay;
      o_parity_err  <= w_perr;
      o_parity_mask <= w_pmask;
      o_proto_err   <= w_proto;
      o_proto_code  <= w_code;
      if (r_clr_cnt) begin
        o_hdr_cnt   <= '0;
        o_pay_cnt   <= '0;
        o_perr_cnt  <= '0;
        o_proto_cnt <= '0;
      end else begin
        o_hdr_cnt   <= sat_inc(o_hdr_cnt, w_hdr_inc);
        o_pay_cnt   <= sat_inc(o_pay_cnt, w_pay_inc);
        o_perr_cnt  <= sat_inc(o_perr_cnt, w_perr);
        o_proto_cnt <= sat_inc(o_proto_cnt, w_proto);
      end
    end
  end

endmodule

// File: tb/tb_siu_dmu_pkt_chk.sv
// Bench for siu_dmu_pkt_chk: packet-level model checked every cycle, plus
// directed scenarios with literal expectations (second instance uses CNT_W=2).
module tb_siu_dmu_pkt_chk;

  localparam int BEATS = 4;

  logic clk = 1'b0;
  logic rst, enable, clr_cnt;
  always #5 clk = ~clk;

  siu_dmu_pkt_chk_if #(.DATA_W(128), .PAR_W(8)) bus_if ();

  logic [127:0] hdr_q, hdr_q2;
  logic         busy, pkt_done, pkt_payload, parity_err, proto_err;
  logic         busy2, pkt_done2, pkt_payload2, parity_err2, proto_err2;
  logic [3:0]   beat_idx, beat_idx2;
  logic [7:0]   parity_mask, parity_mask2;
  logic [1:0]   proto_code, proto_code2;
  logic [15:0]  hdr_cnt, pay_cnt, perr_cnt, proto_cnt;
  logic [1:0]   hdr_cnt2, pay_cnt2, perr_cnt2, proto_cnt2;

  siu_dmu_pkt_chk #(.DATA_W(128), .PAR_W(8), .BEATS(BEATS), .ODD_PARITY(0), .CNT_W(16)) dut (
    .iol2clk(clk), .rst(rst), .i_enable(enable), .i_clr_cnt(clr_cnt), .bus(bus_if.slave),
    .o_hdr_q(hdr_q), .o_busy(busy), .o_beat_idx(beat_idx), .o_pkt_done(pkt_done),
    .o_pkt_payload(pkt_payload), .o_parity_err(parity_err), .o_parity_mask(parity_mask),
    .o_proto_err(proto_err), .o_proto_code(proto_code), .o_hdr_cnt(hdr_cnt),
    .o_pay_cnt(pay_cnt), .o_perr_cnt(perr_cnt), .o_proto_cnt(proto_cnt));

  siu_dmu_pkt_chk #(.DATA_W(128), .PAR_W(8), .BEATS(BEATS), .ODD_PARITY(0), .CNT_W(2)) dut2 (
    .iol2clk(clk), .rst(rst), .i_enable(enable), .i_clr_cnt(clr_cnt), .bus(bus_if.slave),
    .o_hdr_q(hdr_q2), .o_busy(busy2), .o_beat_idx(beat_idx2), .o_pkt_done(pkt_done2),
    .o_pkt_payload(pkt_payload2), .o_parity_err(parity_err2), .o_parity_mask(parity_mask2),
    .o_proto_err(proto_err2), .o_proto_code(proto_code2), .o_hdr_cnt(hdr_cnt2),
    .o_pay_cnt(pay_cnt2), .o_perr_cnt(perr_cnt2), .o_proto_cnt(proto_cnt2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  typedef struct packed {
    logic [127:0]      hdr_q;
    logic              busy;
    logic [3:0]        beat;
    logic              done;
    logic              pay;
    logic              perr;
    logic [7:0]        pmask;
    logic              proto;
    logic [1:0]        code;
    logic [3:0][15:0]  c16;
    logic [3:0][1:0]   c2;
  } exp_t;

  exp_t   pipe1, expv;
  bit     m_in_pkt;
  int     m_beats;
  logic [127:0] m_hdr;
  int     cnt16[4];
  int     cnt2[4];
  bit     chk_en = 1'b0;

  function automatic logic [7:0] model_par(input logic [127:0] d);
    logic [7:0] e;
    for (int s = 0; s < 8; s++) e[s] = ($countones(d[s*16 +: 16]) % 2) == 1;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t o;
    bit   inc[4];
    bit   accept;
    if (rst) begin
      m_in_pkt = 1'b0;
      m_beats  = 0;
      m_hdr    = '0;
      for (int k = 0; k < 4; k++) begin cnt16[k] = 0; cnt2[k] = 0; end
      pipe1 <= '0;
      expv  <= '0;
    end else begin
      o = '0;
      for (int k = 0; k < 4; k++) inc[k] = 1'b0;
      accept = bus_if.hdr_vld && (m_in_pkt || enable);
      if (m_in_pkt && bus_if.hdr_vld) begin
        o.proto = 1'b1; o.code = 2'd1;
      end else if (!m_in_pkt && bus_if.datareq && !bus_if.hdr_vld) begin
        o.proto = 1'b1; o.code = 2'd2;
      end
      if (accept || m_in_pkt) o.pmask = bus_if.parity ^ model_par(bus_if.data);
      o.perr = (o.pmask != 0);
      if (accept) begin
        m_hdr  = bus_if.data;
        inc[0] = 1'b1;
        m_beats = 0;
        m_in_pkt = bus_if.datareq;
        if (!bus_if.datareq) o.done = 1'b1;
      end else if (m_in_pkt) begin
        m_beats++;
        if (m_beats == BEATS) begin
          o.done = 1'b1; o.pay = 1'b1; inc[1] = 1'b1;
          m_in_pkt = 1'b0; m_beats = 0;
        end
      end
      inc[2] = o.perr;
      inc[3] = o.proto;
      for (int k = 0; k < 4; k++) begin
        if (clr_cnt) begin
          cnt16[k] = 0; cnt2[k] = 0;
        end else if (inc[k]) begin
          if (cnt16[k] < 65535) cnt16[k]++;
          if (cnt2[k] < 3) cnt2[k]++;
        end
        o.c16[k] = 16'(cnt16[k]);
        o.c2[k]  = 2'(cnt2[k]);
      end
      o.hdr_q = m_hdr;
      o.busy  = m_in_pkt;
      o.beat  = 4'(m_beats);
      pipe1 <= o;
      expv  <= pipe1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("hdr_q", hdr_q, expv.hdr_q);
      cmp("busy", busy, expv.busy);
      cmp("beat_idx", beat_idx, expv.beat);
      cmp("pkt_done", pkt_done, expv.done);
      cmp("pkt_payload", pkt_payload, expv.pay);
      cmp("parity_err", parity_err, expv.perr);
      cmp("parity_mask", parity_mask, expv.pmask);
      cmp("proto_err", proto_err, expv.proto);
      if (expv.proto) cmp("proto_code", proto_code, expv.code);
      cmp("hdr_cnt", hdr_cnt, expv.c16[0]);
      cmp("pay_cnt", pay_cnt, expv.c16[1]);
      cmp("perr_cnt", perr_cnt, expv.c16[2]);
      cmp("proto_cnt", proto_cnt, expv.c16[3]);
      cmp("hdr_cnt_w2", hdr_cnt2, expv.c2[0]);
      cmp("pay_cnt_w2", pay_cnt2, expv.c2[1]);
      cmp("perr_cnt_w2", perr_cnt2, expv.c2[2]);
      cmp("proto_cnt_w2", proto_cnt2, expv.c2[3]);
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [7:0] good_par(input logic [127:0] d);
    logic [7:0] p = '0;
    for (int b = 0; b < 128; b++) p[b/16] = p[b/16] ^ d[b];
    return p;
  endfunction

  // Drive one input cycle; returns at the following falling edge.
  task automatic step(input logic hv, input logic dr, input logic [127:0] d,
                      input logic [7:0] flip = 8'h00, input logic en = 1'b1,
                      input logic clr = 1'b0, input logic rs = 1'b0);
    bus_if.hdr_vld = hv;
    bus_if.datareq = dr;
    bus_if.data    = d;
    bus_if.parity  = good_par(d) ^ flip;
    enable  = en;
    clr_cnt = clr;
    rst     = rs;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0);
  endtask

  task automatic clear();
    step(1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b1);
  endtask

  function automatic logic [127:0] beat_val(input int i);
    return {4{32'hBEEF_0000 + 32'(i)}};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; clr_cnt = 1'b0;
    bus_if.hdr_vld = 1'b0; bus_if.datareq = 1'b0; bus_if.data = '0; bus_if.parity = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    cmp("rst_hdr_q", hdr_q, 128'h0);
    cmp("rst_busy", busy, 1'b0);
    cmp("rst_hdr_cnt", hdr_cnt, 16'd0);
    cmp("rst_beat_idx", beat_idx, 4'd0);
    idle();

    // payload packet with correct parity
    step(1'b1, 1'b1, 128'hA5);
    step(1'b0, 1'b0, beat_val(0));
    cmp("t1_hdr_q", hdr_q, 128'hA5);
    cmp("t1_busy", busy, 1'b1);
    cmp("t1_hdr_cnt", hdr_cnt, 16'd1);
    for (int i = 1; i < BEATS; i++) step(1'b0, 1'b0, beat_val(i));
    idle();
    cmp("t1_done", pkt_done, 1'b1);
    cmp("t1_payload", pkt_payload, 1'b1);
    cmp("t1_pay_cnt", pay_cnt, 16'd1);
    cmp("t1_perr_cnt", perr_cnt, 16'd0);
    cmp("t1_busy_end", busy, 1'b0);

    // two back-to-back header-only packets
    clear();
    step(1'b1, 1'b0, 128'h1111);
    step(1'b1, 1'b0, 128'h2222);
    cmp("t2_done_a", pkt_done, 1'b1);
    cmp("t2_payload_a", pkt_payload, 1'b0);
    idle();
    cmp("t2_done_b", pkt_done, 1'b1);
    cmp("t2_hdr_cnt", hdr_cnt, 16'd2);
    cmp("t2_busy", busy, 1'b0);
    cmp("t2_hdr_q", hdr_q, 128'h2222);

    // parity error on beat 2
    clear();
    step(1'b1, 1'b1, 128'h33);
    step(1'b0, 1'b0, beat_val(0));
    step(1'b0, 1'b0, beat_val(1));
    step(1'b0, 1'b0, beat_val(2), 8'h08);
    step(1'b0, 1'b0, beat_val(3));
    cmp("t3_perr", parity_err, 1'b1);
    cmp("t3_mask", parity_mask, 8'h08);
    cmp("t3_perr_cnt", perr_cnt, 16'd1);
    idle();
    cmp("t3_done", pkt_done, 1'b1);
    cmp("t3_pay_cnt", pay_cnt, 16'd1);

    // header during beat 1 with a bad parity bit: both errors fire
    clear();
    step(1'b1, 1'b1, 128'h44);
    step(1'b0, 1'b0, beat_val(0));
    step(1'b1, 1'b1, 128'h55, 8'h01);
    step(1'b0, 1'b0, beat_val(0));
    cmp("t4_proto", proto_err, 1'b1);
    cmp("t4_code", proto_code, 2'd1);
    cmp("t4_perr", parity_err, 1'b1);
    cmp("t4_mask", parity_mask, 8'h01);
    cmp("t4_done_none", pkt_done, 1'b0);
    for (int i = 1; i < BEATS; i++) step(1'b0, 1'b0, beat_val(i));
    // back-to-back header right after the last beat, enable dropped mid-packet
    step(1'b1, 1'b1, 128'h66);
    cmp("t4_done", pkt_done, 1'b1);
    cmp("t4_hdr_cnt", hdr_cnt, 16'd2);
    cmp("t4_pay_cnt", pay_cnt, 16'd1);
    cmp("t4_proto_cnt", proto_cnt, 16'd1);
    for (int i = 0; i < BEATS; i++) step(1'b0, 1'b0, beat_val(i), 8'h00, 1'b0);
    idle();
    cmp("t4b_done", pkt_done, 1'b1);
    cmp("t4b_pay_cnt", pay_cnt, 16'd2);

    // disabled header ignored, orphan datareq, then reset mid-payload
    clear();
    step(1'b1, 1'b1, 128'h77, 8'h00, 1'b0);
    step(1'b0, 1'b1, 128'h0);
    cmp("t5_ign_cnt", hdr_cnt, 16'd0);
    cmp("t5_ign_busy", busy, 1'b0);
    idle();
    cmp("t5_proto", proto_err, 1'b1);
    cmp("t5_code", proto_code, 2'd2);
    cmp("t5_proto_cnt", proto_cnt, 16'd1);
    step(1'b1, 1'b1, 128'h88);
    step(1'b0, 1'b0, beat_val(0));
    step(1'b0, 1'b0, beat_val(1), 8'h00, 1'b1, 1'b0, 1'b1);
    cmp("t5_rst_busy", busy, 1'b0);
    cmp("t5_rst_hdr_q", hdr_q, 128'h0);
    cmp("t5_rst_cnt", proto_cnt, 16'd0);
    step(1'b0, 1'b0, beat_val(2));
    step(1'b0, 1'b0, beat_val(3));
    cmp("t5_post_busy", busy, 1'b0);
    cmp("t5_post_done", pkt_done, 1'b0);
    cmp("t5_post_hdr_cnt", hdr_cnt, 16'd0);

    // saturation in the narrow-counter instance, clr_cnt beats increment
    clear();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 128'(i + 1));
    idle();
    cmp("t6_sat_w2", hdr_cnt2, 2'd3);
    cmp("t6_cnt_w16", hdr_cnt, 16'd5);
    step(1'b1, 1'b0, 128'h99, 8'h00, 1'b1, 1'b1);
    idle();
    cmp("t6_clr_w2", hdr_cnt2, 2'd0);
    cmp("t6_clr_w16", hdr_cnt, 16'd0);
    cmp("t6_clr_done", pkt_done, 1'b1);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
